// File: rtl/bus_src_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bus_src_fifo
//  Description : First-word-fall-through source FIFO feeding one port of the
//                bus arbiter. The head packet is presented on D_pop with
//                pndng, and the arbiter dequeues it with pop. A sticky
//                underflow flag records any pop seen while empty.
//                Optional feature macro: BUS_SRC_FIFO_OVFL_CNT_EN adds an
//                8-bit saturating count of dropped (overflowing) writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_src_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  output logic                       full,
  input  logic                       pop,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  output logic [$clog2(depth+1)-1:0] count,
`ifdef BUS_SRC_FIFO_OVFL_CNT_EN
  output logic [7:0]                 ovfl_cnt,
`endif
  output logic                       undf
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth+1);
  localparam logic [CW-1:0] c_depth = CW'(depth);
  localparam logic [CW-1:0] c_one   = CW'(1);
  localparam logic [AW-1:0] c_ptr1  = AW'(1);

  logic [pckg_sz-1:0] r_mem [depth];
  logic [AW-1:0]      r_rdptr;
  logic [AW-1:0]      r_wrptr;
  logic [CW-1:0]      r_count;
  logic               r_undf;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_wr_ok;
  logic w_undf_set;
  logic w_drop;

  // Status is a pure function of the occupancy register, so the arbiter never
  // sees a combinational path from wr_en or pop.
  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == c_depth);
    // A pop is honoured whenever something is stored; at full this frees the
    // slot that a same-cycle write then takes.
    w_pop_ok   = pop && !w_empty;
    w_wr_ok    = wr_en && (!w_full || w_pop_ok);
    // A pop paired with a write on an empty FIFO is not an underflow.
    w_undf_set = pop && w_empty && !wr_en;
    w_drop     = wr_en && w_full && !pop;
  end

  // Storage array: written only on an accepted write, never reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wrptr] <= wr_data;
    end
  end

  // Pointers, occupancy and sticky underflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdptr <= '0;
      r_wrptr <= '0;
      r_count <= '0;
      r_undf  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wrptr <= r_wrptr + c_ptr1;
      end
      if (w_pop_ok) begin
        r_rdptr <= r_rdptr + c_ptr1;
      end
      case ({w_wr_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
      if (w_undf_set) begin
        r_undf <= 1'b1;
      end
    end
  end

`ifdef BUS_SRC_FIFO_OVFL_CNT_EN
  logic [7:0] r_ovfl_cnt;

  // Saturating count of writes discarded because the FIFO was full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovfl_cnt <= 8'd0;
    end else if (w_drop && (r_ovfl_cnt != 8'hFF)) begin
      r_ovfl_cnt <= r_ovfl_cnt + 8'd1;
    end
  end

  assign ovfl_cnt = r_ovfl_cnt;
`else
  logic w_drop_unused;
  assign w_drop_unused = w_drop;
`endif

  // Head is forced to zero when empty so stale array contents never leak out.
  always_comb begin
    D_pop = w_empty ? '0 : r_mem[r_rdptr];
  end

  assign full  = w_full;
  assign pndng = !w_empty;
  assign count = r_count;
  assign undf  = r_undf;

endmodule
`default_nettype wire

// File: tb/tb_bus_src_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_src_fifo
//  Description : Self-checking bench for bus_src_fifo (pckg_sz=16, depth=8).
//                A queue-based reference model tracks expected contents and
//                flags; a compare process checks every falling edge, and
//                directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_src_fifo;

  localparam int PW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [PW-1:0] wr_data = '0;
  logic          pop = 1'b0;
  logic          full;
  logic          pndng;
  logic [PW-1:0] D_pop;
  logic [CW-1:0] count;
  logic          undf;
`ifdef BUS_SRC_FIFO_OVFL_CNT_EN
  logic [7:0]    ovfl_cnt;
`endif

  int passed = 0;
  int total  = 0;
  bit armed  = 1'b0;

  bus_src_fifo #(.pckg_sz(PW), .depth(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .pop     (pop),
    .pndng   (pndng),
    .D_pop   (D_pop),
    .count   (count),
`ifdef BUS_SRC_FIFO_OVFL_CNT_EN
    .ovfl_cnt(ovfl_cnt),
`endif
    .undf    (undf)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, flags as plain variables.
  logic [PW-1:0] m_q[$];
  bit            m_undf = 1'b0;
  int            m_ovfl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  // Model update on each rising edge using the inputs held since the falling edge.
  always @(posedge clk) begin
    if (reset) begin
      int  sz;
      bit  dp, dw;
      sz = m_q.size();
      dp = pop && (sz > 0);
      dw = wr_en && ((sz < DEPTH) || dp);
      if (pop && (sz == 0) && !wr_en) m_undf = 1'b1;
      if (wr_en && (sz == DEPTH) && !pop && (m_ovfl < 255)) m_ovfl++;
      if (dp) void'(m_q.pop_front());
      if (dw) m_q.push_back(wr_data);
    end
  end

  // Asynchronous reset empties the model as well.
  always @(negedge reset) begin
    m_q.delete();
    m_undf = 1'b0;
    m_ovfl = 0;
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("cmp_count", 32'(count), 32'(m_q.size()));
      chk("cmp_full",  32'(full),  32'(m_q.size() == DEPTH));
      chk("cmp_pndng", 32'(pndng), 32'(m_q.size() != 0));
      chk("cmp_dpop",  32'(D_pop), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
      chk("cmp_undf",  32'(undf),  32'(m_undf));
`ifdef BUS_SRC_FIFO_OVFL_CNT_EN
      chk("cmp_ovfl",  32'(ovfl_cnt), 32'(m_ovfl));
`endif
    end
  end

  // One clock cycle: inputs applied at the falling edge, outputs settle just after the rising edge.
  task automatic step(input logic w, input logic [PW-1:0] d, input logic p);
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    pop     = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pndng", 32'(pndng), 32'd0);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_dpop",  32'(D_pop), 32'd0);
    chk("rst_undf",  32'(undf),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    armed = 1'b1;

    // Single write then pop.
    step(1'b1, 16'hA5A5, 1'b0);
    chk("single_dpop",  32'(D_pop), 32'h0000A5A5);
    chk("single_pndng", 32'(pndng), 32'd1);
    chk("single_count", 32'(count), 32'd1);
    step(1'b0, 16'h0, 1'b1);
    chk("single_pop_pndng", 32'(pndng), 32'd0);
    chk("single_pop_dpop",  32'(D_pop), 32'd0);
    chk("single_pop_count", 32'(count), 32'd0);

    // Fill to full, ninth write dropped, drain in order.
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, PW'(i), 1'b0);
      if (i == 8) begin
        chk("fill_full8",  32'(full),  32'd1);
        chk("fill_count8", 32'(count), 32'd8);
      end
    end
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_head",  32'(D_pop), 32'd1);
`ifdef BUS_SRC_FIFO_OVFL_CNT_EN
    chk("ovf_cnt", 32'(ovfl_cnt), 32'd1);
`endif
    for (int i = 1; i <= 8; i++) begin
      chk("drain_head", 32'(D_pop), 32'(i));
      step(1'b0, 16'h0, 1'b1);
    end
    chk("drain_empty", 32'(pndng), 32'd0);

    // Simultaneous write and pop at full.
    for (int i = 0; i < 8; i++) step(1'b1, PW'(16'h0010 + i), 1'b0);
    step(1'b1, 16'hBEEF, 1'b1);
    chk("both_full_count", 32'(count), 32'd8);
    chk("both_full_head",  32'(D_pop), 32'h11);
    for (int i = 1; i <= 8; i++) begin
      chk("both_drain_head", 32'(D_pop), (i == 8) ? 32'hBEEF : 32'(16'h0010 + i));
      step(1'b0, 16'h0, 1'b1);
    end
    chk("both_drain_empty", 32'(count), 32'd0);

    // Empty-state corners.
    step(1'b0, 16'h0, 1'b1);
    chk("undf_set",   32'(undf),  32'd1);
    chk("undf_count", 32'(count), 32'd0);
    step(1'b1, 16'h5555, 1'b1);
    chk("empty_both_count", 32'(count), 32'd1);
    chk("empty_both_undf",  32'(undf),  32'd1);
    chk("empty_both_head",  32'(D_pop), 32'h5555);
    step(1'b0, 16'h0, 1'b1);

    // Continuous write+pop across pointer wrap.
    step(1'b1, 16'h0100, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, PW'(16'h0101 + i), 1'b1);
      chk("wrap_count", 32'(count), 32'd1);
      chk("wrap_head",  32'(D_pop), 32'(16'h0101 + i));
    end
    step(1'b0, 16'h0, 1'b1);

    // Mid-operation reset with five entries, write held across reset.
    for (int i = 0; i < 5; i++) step(1'b1, PW'(16'h0A00 + i), 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 16'hDEAD; pop = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_pndng", 32'(pndng), 32'd0);
    chk("midrst_dpop",  32'(D_pop), 32'd0);
    chk("midrst_undf",  32'(undf),  32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_count", 32'(count), 32'd0);
    @(negedge clk);
    wr_en = 1'b0; pop = 1'b0;
    reset = 1'b1;
    step(1'b1, 16'h1234, 1'b0);
    chk("post_rst_head",  32'(D_pop), 32'h1234);
    chk("post_rst_count", 32'(count), 32'd1);
    step(1'b0, 16'h0, 1'b0);
    @(negedge clk);
    armed = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
